// File: rtl/tone_arbiter.sv
// tone_arbiter: round-robin arbiter that hands a single tone generator to one
// of N_REQ requesters for a note of req_dur milliseconds.
// Optional macro TONE_ARB_GAP_EN adds a GAP_MS silence after every note.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no note owned; arbitrate among active req bits
// PLAY  | winner owns the generator; ms prescaler/counter time the note
// GAP   | forced silence after a note (only with TONE_ARB_GAP_EN)
`timescale 1ns/1ps

module tone_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 50000,
    parameter int GAP_MS   = 10
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [24*N_REQ-1:0]  req_period,
    input  logic [16*N_REQ-1:0]  req_dur,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [23:0]          period,
    output logic                 tone_en,
    output logic                 busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

`ifdef TONE_ARB_GAP_EN
    localparam int GAP_CYC = GAP_MS * TICK_DIV;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
`else
    localparam int unused_gap_ms = GAP_MS;
    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
`endif

    state_t          state, state_n;
    logic [IW-1:0]   last_served;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            found;
    logic [23:0]     win_period;
    logic [15:0]     win_dur;
    logic [15:0]     dur_q;
    logic [PW-1:0]   presc;
    logic [15:0]     ms_cnt;
    logic            held;
    logic            play_last;

`ifdef TONE_ARB_GAP_EN
    logic [GW-1:0]   gap_cnt;
`endif

    // Round-robin search starting one past the last requester served.
    always_comb begin
        found = 1'b0;
        win   = last_served;
        cand  = last_served;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_served) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Select the winner's period and duration fields.
    always_comb begin
        win_period = '0;
        win_dur    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == win) begin
                win_period = req_period[24*i +: 24];
                win_dur    = req_dur[16*i +: 16];
            end
        end
    end

    // A zero-length note still occupies one PLAY cycle.
    assign held      = |(req & grant);
    assign play_last = (state == PLAY) &&
                       ((dur_q == 16'd0) ||
                        ((presc == PRE_LAST) && (ms_cnt == dur_q - 16'd1)));

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and Moore/Mealy outputs; done is suppressed by an abort or reset.
    always_comb begin
        state_n = state;
        done    = '0;
        tone_en = 1'b0;
        busy    = (state != IDLE);
        case (state)
            IDLE: begin
                if (found) state_n = PLAY;
            end
            PLAY: begin
                tone_en = (period >= 24'd2) && (dur_q != 16'd0);
                if (!held || play_last) begin
`ifdef TONE_ARB_GAP_EN
                    state_n = GAP;
`else
                    state_n = IDLE;
`endif
                end
                if (held && play_last && !reset) done = grant;
            end
`ifdef TONE_ARB_GAP_EN
            GAP: begin
                if (gap_cnt == GAP_LAST) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Grant, latched note parameters and the ms timer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            grant       <= '0;
            period      <= '0;
            dur_q       <= '0;
            presc       <= '0;
            ms_cnt      <= '0;
            last_served <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant       <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                        period      <= win_period;
                        dur_q       <= win_dur;
                        presc       <= '0;
                        ms_cnt      <= '0;
                        last_served <= win;
                    end
                end
                PLAY: begin
                    if (!held || play_last) begin
                        grant <= '0;
                    end else if (presc == PRE_LAST) begin
                        presc  <= '0;
                        ms_cnt <= ms_cnt + 16'd1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TONE_ARB_GAP_EN
    // Silence timer, cleared whenever the FSM is outside GAP.
    always_ff @(posedge CLOCK_50) begin
        if (reset || state != GAP) gap_cnt <= '0;
        else                       gap_cnt <= gap_cnt + GW'(1);
    end
`endif

endmodule

// File: tb/tb_tone_arbiter.sv
// Testbench for tone_arbiter (TICK_DIV=10, N_REQ=4, GAP_MS=2).
`timescale 1ns/1ps

module tb_tone_arbiter;

    localparam int N   = 4;
    localparam int TD  = 10;
    localparam int GMS = 2;
`ifdef TONE_ARB_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [95:0]   req_period = '0;
    logic [63:0]   req_dur = '0;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [23:0]   period;
    logic          tone_en;
    logic          busy;

    tone_arbiter #(.N_REQ(N), .TICK_DIV(TD), .GAP_MS(GMS)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req        (req),
        .req_period (req_period),
        .req_dur    (req_dur),
        .grant      (grant),
        .done       (done),
        .period     (period),
        .tone_en    (tone_en),
        .busy       (busy)
    );

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] gcyc;
        logic [15:0] tcyc;
        logic        dn;
        logic [23:0] per;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_mem[64];
    int   obs_wr = 0;
    int   obs_rd = 0;
    rec_t cur;
    bit   act = 1'b0;
    int   spur = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic rec_t mk(int id, int g, int t, bit d, int p);
        return {8'(id), 16'(g), 16'(t), d, 24'(p)};
    endfunction

    function automatic string fmt(rec_t r);
        return $sformatf("id=%0d grant_cyc=%0d tone_cyc=%0d done=%0b period=%0d",
                         r.id, r.gcyc, r.tcyc, r.dn, r.per);
    endfunction

    // Note monitor: one record per grant, pushed when the grant falls.
    initial forever begin
        @(negedge CLOCK_50);
        if (tone_en && grant == '0) spur++;
        if (done != '0 && done != grant) spur++;
        if (grant != '0) begin
            if ($countones(grant) != 1) spur++;
            if (!act) begin
                act = 1'b1;
                cur = '0;
                for (int i = 0; i < N; i++) if (grant[i]) cur.id = 8'(i);
                cur.per = period;
            end
            cur.gcyc = cur.gcyc + 16'd1;
            if (tone_en) cur.tcyc = cur.tcyc + 16'd1;
            if (done != '0) cur.dn = 1'b1;
        end else if (act) begin
            obs_mem[obs_wr % 64] = cur;
            obs_wr++;
            act = 1'b0;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    // Wait until `upto` notes are recorded; drop all req one cycle after the
    // drop_after-th done pulse (0 = never drop).
    task automatic wait_notes(input int upto, input int drop_after, output bit ok);
        int  dones = 0;
        bit  drop = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge CLOCK_50);
            if (drop) req = '0;
            if (done != '0) begin
                dones++;
                if (dones == drop_after) drop = 1'b1;
            end
            if (obs_wr >= upto) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL rst_done got %b want 0000", done); end
        checks++; if (period !== 24'd0) begin errors++; $display("FAIL rst_period got %0d want 0", period); end
        checks++; if (tone_en !== 1'b0) begin errors++; $display("FAIL rst_tone_en got %b want 0", tone_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        rec_t e, o;
        bit   ok;
        do_reset();
        req_period[23:0] = 24'd382;
        req_dur[15:0]    = 16'd3;
        req              = 4'b0001;
        exp_q.push_back(mk(0, 30, 30, 1'b1, 382));
        @(negedge CLOCK_50);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_latency got %b want 0001", grant); end
        wait_notes(obs_rd + 1, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got none want 1 note"); end
        if (ok) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd % 64]; obs_rd++;
            checks++; if (o !== e) begin errors++; $display("FAIL single_note got %s want %s", fmt(o), fmt(e)); end
        end
        repeat (3) @(negedge CLOCK_50);
        checks++; if (period !== 24'd382) begin errors++; $display("FAIL single_period_hold got %0d want 382", period); end
    endtask

    task automatic test_round_robin();
        rec_t e, o;
        bit   ok;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_period[24*i +: 24] = (i == 3) ? 24'd1 : 24'(100 * (i + 1));
            req_dur[16*i +: 16]    = 16'd1;
        end
        exp_q.push_back(mk(0, 10, 10, 1'b1, 100));
        exp_q.push_back(mk(1, 10, 10, 1'b1, 200));
        exp_q.push_back(mk(2, 10, 10, 1'b1, 300));
        exp_q.push_back(mk(3, 10, 0, 1'b1, 1));
        exp_q.push_back(mk(0, 10, 10, 1'b1, 100));
        req = 4'b1111;
        wait_notes(obs_rd + 5, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d notes want 5", obs_wr - obs_rd); end
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                e = exp_q.pop_front(); o = obs_mem[obs_rd % 64]; obs_rd++;
                checks++; if (o !== e) begin errors++; $display("FAIL rr_note_%0d got %s want %s", k, fmt(o), fmt(e)); end
            end
        end
    endtask

    task automatic test_abort();
        rec_t e, o;
        bit   ok;
        int   g = 0;
        do_reset();
        req_period[2*24 +: 24] = 24'd250;
        req_dur[2*16 +: 16]    = 16'd5;
        req_period[3*24 +: 24] = 24'd77;
        req_dur[3*16 +: 16]    = 16'd1;
        req = 4'b0100;
        exp_q.push_back(mk(2, 12, 12, 1'b0, 250));
        exp_q.push_back(mk(3, 10, 10, 1'b1, 77));
        for (int c = 0; c < 100 && g < 12; c++) begin
            @(negedge CLOCK_50);
            if (grant != '0) g++;
        end
        req = 4'b0000;
        checks++; if (g !== 12) begin errors++; $display("FAIL abort_reach got %0d want 12", g); end
        @(negedge CLOCK_50);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant got %b want 0000", grant); end
        checks++; if (tone_en !== 1'b0) begin errors++; $display("FAIL abort_tone_en got %b want 0", tone_en); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL abort_done got %b want 0000", done); end
        checks++; if (busy !== GAP_ON) begin errors++; $display("FAIL abort_busy got %b want %b", busy, GAP_ON); end
        req = 4'b1001;
        for (int c = 0; c < 100 && grant == '0; c++) @(negedge CLOCK_50);
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL abort_next_rr got %b want 1000", grant); end
        wait_notes(obs_rd + 2, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_timeout got %0d notes want 2", obs_wr - obs_rd); end
        if (ok) begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front(); o = obs_mem[obs_rd % 64]; obs_rd++;
                checks++; if (o !== e) begin errors++; $display("FAIL abort_note_%0d got %s want %s", k, fmt(o), fmt(e)); end
            end
        end
    endtask

    task automatic test_dur_zero();
        rec_t e, o;
        bit   ok;
        do_reset();
        req_period[1*24 +: 24] = 24'd900;
        req_dur[1*16 +: 16]    = 16'd0;
        req = 4'b0010;
        exp_q.push_back(mk(1, 1, 0, 1'b1, 900));
        wait_notes(obs_rd + 1, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dur0_timeout got none want 1 note"); end
        if (ok) begin
            e = exp_q.pop_front(); o = obs_mem[obs_rd % 64]; obs_rd++;
            checks++; if (o !== e) begin errors++; $display("FAIL dur0_note got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_reset_mid_play();
        rec_t e, o;
        bit   ok;
        int   g = 0;
        do_reset();
        req_period[23:0] = 24'd500;
        req_dur[15:0]    = 16'd3;
        req = 4'b0001;
        exp_q.push_back(mk(0, 7, 7, 1'b0, 500));
        exp_q.push_back(mk(0, 30, 30, 1'b1, 500));
        for (int c = 0; c < 100 && g < 7; c++) begin
            @(negedge CLOCK_50);
            if (grant != '0) g++;
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL midrst_done got %b want 0000", done); end
        checks++; if (period !== 24'd0) begin errors++; $display("FAIL midrst_period got %0d want 0", period); end
        checks++; if (tone_en !== 1'b0) begin errors++; $display("FAIL midrst_tone_en got %b want 0", tone_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        reset = 1'b0;
        wait_notes(obs_rd + 2, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got %0d notes want 2", obs_wr - obs_rd); end
        if (ok) begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front(); o = obs_mem[obs_rd % 64]; obs_rd++;
                checks++; if (o !== e) begin errors++; $display("FAIL midrst_note_%0d got %s want %s", k, fmt(o), fmt(e)); end
            end
        end
    endtask

`ifdef TONE_ARB_GAP_EN
    task automatic test_gap();
        rec_t e, o;
        bit   ok;
        int   sil = 0;
        do_reset();
        req_period[23:0]  = 24'd300;
        req_period[47:24] = 24'd301;
        req_dur[15:0]     = 16'd1;
        req_dur[31:16]    = 16'd1;
        req = 4'b0011;
        exp_q.push_back(mk(0, 10, 10, 1'b1, 300));
        exp_q.push_back(mk(1, 10, 10, 1'b1, 301));
        for (int c = 0; c < 50 && grant != 4'b0001; c++) @(negedge CLOCK_50);
        for (int c = 0; c < 50 && grant != 4'b0000; c++) @(negedge CLOCK_50);
        for (int c = 0; c < 100 && busy && grant == '0 && !tone_en; c++) begin
            sil++;
            @(negedge CLOCK_50);
        end
        checks++; if (sil !== 2 * GMS * TD / 2 * 1) begin errors++; $display("FAIL gap_len got %0d want %0d", sil, GMS * TD); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_idle_busy got %b want 0", busy); end
        @(negedge CLOCK_50);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL gap_next_grant got %b want 0010", grant); end
        wait_notes(obs_rd + 2, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gap_timeout got %0d notes want 2", obs_wr - obs_rd); end
        if (ok) begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front(); o = obs_mem[obs_rd % 64]; obs_rd++;
                checks++; if (o !== e) begin errors++; $display("FAIL gap_note_%0d got %s want %s", k, fmt(o), fmt(e)); end
            end
        end
    endtask
`endif

    task automatic test_no_spurious();
        checks++; if (spur !== 0) begin errors++; $display("FAIL spurious_events got %0d want 0", spur); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_dur_zero();
        test_reset_mid_play();
`ifdef TONE_ARB_GAP_EN
        test_gap();
`endif
        test_no_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 50000, giving CLOCK_50 cycles per 1 ms tick.
REQ-003 The block SHALL have parameter GAP_MS, default 10, giving the silence length in ms (used only with GAP_EN).
REQ-004 CLOCK_50  input  1  system clock; all logic is on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester request level.
REQ-007 req_period  input  24*N_REQ  tone period; requester i occupies bits [24i+23:24i].
REQ-008 req_dur  input  16*N_REQ  note duration in ms; requester i occupies bits [16i+15:16i].
REQ-009 grant  output  N_REQ  one-hot grant; high while requester's note is owned.
REQ-010 done  output  N_REQ  one-cycle completion pulse for the requester.
REQ-011 period  output  24  latched period that drives the clock-divider period input.
REQ-012 tone_en  output  1  high while a tone plays; the divider reset is ~tone_en.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, PLAY and GAP; GAP exists only with GAP_EN.
REQ-015 In IDLE with any req bit high, the next state SHALL be PLAY, with grant registered exactly 1 cycle after req is sampled.
REQ-016 Arbitration SHALL be round-robin: search starts at last_served+1 mod N_REQ, and last_served resets to N_REQ-1 so requester 0 wins first.
REQ-017 On grant, req_period and req_dur of the winner SHALL be latched; later input changes SHALL have no effect until the next grant.
REQ-018 tone_en SHALL be high in PLAY only when the latched period is >= 2; when the period is < 2, PLAY SHALL time silently.
REQ-019 On PLAY entry, the ms prescaler (0..TICK_DIV-1) and the ms counter SHALL both restart at 0.
REQ-020 PLAY SHALL last exactly dur*TICK_DIV cycles; on the last cycle, done[i] SHALL pulse and the grant SHALL drop on the following cycle.
REQ-021 A latched dur of 0 SHALL spend 1 cycle in PLAY with tone_en low, then pulse done.
REQ-022 If req[granted] falls during PLAY, the note SHALL abort on the next cycle: grant and tone_en low, no done pulse, last_served updated.
REQ-023 After PLAY, the next state SHALL be GAP (GAP_EN) or IDLE, and a requester still holding req SHALL re-arbitrate in IDLE normally.
REQ-024 The period output SHALL hold the last latched value outside PLAY.
REQ-025 The ms counter SHALL be 16 bits and the prescaler SHALL be $clog2(TICK_DIV) bits, with no wrap for any legal dur.

Reset
REQ-026 Reset SHALL override all other activity, including mid-PLAY.
REQ-027 On reset, the state SHALL be IDLE, with grant=0, done=0, period=0, tone_en=0, busy=0, counters=0 and last_served=N_REQ-1.
REQ-028 reset high mid-note SHALL produce no done pulse.

Configuration
REQ-029 With macro TONE_ARB_GAP_EN defined, each completed or aborted note SHALL be followed by GAP_MS*TICK_DIV cycles in GAP with tone_en=0, grant=0 and busy=1, then IDLE.
REQ-030 Without TONE_ARB_GAP_EN, PLAY SHALL return directly to IDLE, and the GAP state and its counter SHALL not be synthesised.

Verification (bench uses TICK_DIV=10, N_REQ=4)
REQ-031 req=0001, period0=382, dur0=3 -> grant=0001 1 cycle later; tone_en high 30 cycles; done[0] pulse on cycle 30; period=382.
REQ-032 req=1111 held, all dur=1 -> grant order 0,1,2,3,0; each grant lasts 10 cycles.
REQ-033 req=0100, dur2=5, req2 dropped after 12 PLAY cycles -> abort next cycle; no done; tone_en low.
REQ-034 req=0010, dur1=0 -> 1 PLAY cycle; tone_en never high; done[1] pulse.
REQ-035 reset asserted on PLAY cycle 7 -> next cycle all outputs 0 and IDLE; reset released with req=0001 -> requester 0 granted fresh, full duration.
REQ-036 With TONE_ARB_GAP_EN, GAP_MS=2, req=0011, dur=1 -> 10 tone cycles, 20 silent busy cycles, then grant=0010.
